// File: rtl/vga_block_renderer_if.sv
// Grid-memory read port, pixel tick and VGA pin bundle for the block renderer.
// master = renderer side, slave = memory/pixel-clock/pin side.
interface vga_block_renderer_if #(
    parameter int ADDR_W         = 11,
    parameter int BITS_PER_BLOCK = 2
);
    logic                      PixelEn;
    logic [ADDR_W-1:0]         ReadAddr;
    logic [BITS_PER_BLOCK-1:0] ReadData;
    logic [7:0]                RGB;
    logic                      HSync;
    logic                      VSync;
    logic                      VBlankStart;

    modport master (
        input  PixelEn, ReadData,
        output ReadAddr, RGB, HSync, VSync, VBlankStart
    );
    modport slave (
        output PixelEn, ReadData,
        input  ReadAddr, RGB, HSync, VSync, VBlankStart
    );
endinterface

// File: rtl/vga_block_renderer.sv
// Scans the VGA raster, reads one block code per cell and drives RGB332 plus syncs.
// Two PixelEn ticks from raster position to pins; no backpressure, everything advances only on PixelEn.
module vga_block_renderer #(
    parameter int         GRID_WIDTH     = 40,
    parameter int         GRID_HEIGHT    = 30,
    parameter int         BITS_PER_BLOCK = 2,
    parameter int         CELL_LOG2      = 4,
    parameter int         ADDR_W         = 11,
    parameter logic [7:0] COLOR_EMPTY    = 8'h00,
    parameter logic [7:0] COLOR_WALL     = 8'h92,
    parameter logic [7:0] COLOR_SNAKE    = 8'h1C,
    parameter logic [7:0] COLOR_FOOD     = 8'hE0,
    parameter int         H_VISIBLE      = 640,
    parameter int         H_SYNC_START   = 656,
    parameter int         H_SYNC_END     = 751,
    parameter int         H_TOTAL        = 800,
    parameter int         V_VISIBLE      = 480,
    parameter int         V_SYNC_START   = 490,
    parameter int         V_SYNC_END     = 491,
    parameter int         V_TOTAL        = 525
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    vga_block_renderer_if.master bus
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
    localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END);
    localparam logic [HW-1:0] GW_C   = HW'(GRID_WIDTH);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
    localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_END);
    localparam logic [VW-1:0] GH_C   = VW'(GRID_HEIGHT);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [HW-1:0]     col;
    logic [VW-1:0]     row;
    logic              in_grid;
    logic              visible;
    logic              hsync_n;
    logic              vsync_n;
    logic              vblank_hit;
    logic [ADDR_W-1:0] cell_addr;

    logic [ADDR_W-1:0] read_addr;
    logic              s1_show;
    logic              s1_hsync;
    logic              s1_vsync;
    logic              s1_vblank;

    logic [7:0]        color;
    logic [7:0]        rgb;
    logic              hsync;
    logic              vsync;
    logic              vblank_start;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (bus.PixelEn) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    always_comb begin
        col        = h_cnt >> CELL_LOG2;
        row        = v_cnt >> CELL_LOG2;
        in_grid    = (col < GW_C) && (row < GH_C);
        visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_n    = !((h_cnt >= H_SS) && (h_cnt <= H_SE));
        vsync_n    = !((v_cnt >= V_SS) && (v_cnt <= V_SE));
        vblank_hit = (v_cnt == V_VIS) && (h_cnt == '0);
        // Only used when in_grid, so row*GRID_WIDTH+col < GRID_WIDTH*GRID_HEIGHT always fits ADDR_W.
        cell_addr  = ADDR_W'(row) * ADDR_W'(GRID_WIDTH) + ADDR_W'(col);
    end

    // Stage 1: issue the memory read and capture the raster flags for this position.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            read_addr <= '0;
            s1_show   <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
            s1_vblank <= 1'b0;
        end else if (bus.PixelEn) begin
            if (in_grid) begin
                read_addr <= cell_addr;
            end
            s1_show   <= visible && in_grid;
            s1_hsync  <= hsync_n;
            s1_vsync  <= vsync_n;
            s1_vblank <= vblank_hit;
        end
    end

    always_comb begin
        color = COLOR_EMPTY;
        if (bus.ReadData == BITS_PER_BLOCK'(1)) begin
            color = COLOR_WALL;
        end else if (bus.ReadData == BITS_PER_BLOCK'(2)) begin
            color = COLOR_SNAKE;
        end else if (bus.ReadData == BITS_PER_BLOCK'(3)) begin
            color = COLOR_FOOD;
        end
    end

    // Stage 2: read data has had at least one Clock since the address moved.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rgb          <= 8'h00;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            vblank_start <= 1'b0;
        end else if (bus.PixelEn) begin
            rgb          <= s1_show ? color : 8'h00;
            hsync        <= s1_hsync;
            vsync        <= s1_vsync;
            vblank_start <= s1_vblank;
        end
    end

    assign bus.ReadAddr    = read_addr;
    assign bus.RGB         = rgb;
    assign bus.HSync       = hsync;
    assign bus.VSync       = vsync;
    assign bus.VBlankStart = vblank_start;
endmodule
